// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Horizontal/vertical counters with phase FSMs; every output is registered
// and decoded from the next-count values, so outputs never lag the counters.
// Optional macro VGA_CLK_DIV_EN: pixel tick on every second clk edge
// (default build: every clk edge is a pixel tick).
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0,
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 video_on,
  output logic                 hsync,
  output logic                 vsync,
  output logic [CNT_WIDTH-1:0] pixel_x,
  output logic [CNT_WIDTH-1:0] pixel_y,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_WIDTH-1:0] H_LAST   = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] H_FP_BEG = CNT_WIDTH'(H_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] H_SY_BEG = CNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [CNT_WIDTH-1:0] H_BP_BEG = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_WIDTH-1:0] V_LAST   = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_FP_BEG = CNT_WIDTH'(V_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] V_SY_BEG = CNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [CNT_WIDTH-1:0] V_BP_BEG = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic                 SYNC_ON  = 1'(SYNC_POL);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_e;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_state_e;

  logic [CNT_WIDTH-1:0] h_q, h_d, v_q, v_d;
  logic [CNT_WIDTH-1:0] h_nxt, v_nxt;
  h_state_e             h_st_q, h_st_d, h_st_nxt;
  v_state_e             v_st_q, v_st_d, v_st_nxt;
  logic                 h_wrap;
  logic                 tick;

  logic                 video_on_q, video_on_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 frame_start_q, frame_start_d;
  logic [CNT_WIDTH-1:0] pixel_x_q, pixel_x_d;
  logic [CNT_WIDTH-1:0] pixel_y_q, pixel_y_d;

`ifdef VGA_CLK_DIV_EN
  logic tog_q, tog_d;

  // Pixel-rate divider: tick is high on every second clk edge after reset.
  always_comb begin
    tog_d = ~tog_q;
    tick  = tog_q;
  end

  // Divider toggle register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tog_q <= 1'b0;
    else        tog_q <= tog_d;
  end
`else
  // Every clk edge is a pixel tick.
  always_comb tick = 1'b1;
`endif

  // Next counts and next phase states; outputs are decoded from these so
  // they line up with the counters on the same edge.
  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_nxt  = h_wrap ? '0 : h_q + 1'b1;
    if (h_wrap) v_nxt = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    else        v_nxt = v_q;

    h_st_nxt = h_st_q;
    if (h_nxt == '0)           h_st_nxt = H_ACT;
    else if (h_nxt == H_FP_BEG) h_st_nxt = H_FRONT;
    else if (h_nxt == H_SY_BEG) h_st_nxt = H_SYNCP;
    else if (h_nxt == H_BP_BEG) h_st_nxt = H_BACK;

    // Vertical phase only moves on the horizontal wrap.
    v_st_nxt = v_st_q;
    if (h_wrap) begin
      if (v_nxt == '0)            v_st_nxt = V_ACT;
      else if (v_nxt == V_FP_BEG) v_st_nxt = V_FRONT;
      else if (v_nxt == V_SY_BEG) v_st_nxt = V_SYNCP;
      else if (v_nxt == V_BP_BEG) v_st_nxt = V_BACK;
    end
  end

  // Register update values: everything holds between pixel ticks.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    h_st_d        = h_st_q;
    v_st_d        = v_st_q;
    video_on_d    = video_on_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = frame_start_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    if (tick) begin
      h_d           = h_nxt;
      v_d           = v_nxt;
      h_st_d        = h_st_nxt;
      v_st_d        = v_st_nxt;
      video_on_d    = (h_st_nxt == H_ACT) && (v_st_nxt == V_ACT);
      hsync_d       = (h_st_nxt == H_SYNCP) ? SYNC_ON : ~SYNC_ON;
      vsync_d       = (v_st_nxt == V_SYNCP) ? SYNC_ON : ~SYNC_ON;
      frame_start_d = (h_nxt == '0) && (v_nxt == '0);
      pixel_x_d     = h_nxt;
      pixel_y_d     = v_nxt;
    end
  end

  // Counter, FSM and output state. Reset parks the counters on the last
  // pixel of the frame so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      h_st_q        <= H_BACK;
      v_st_q        <= V_BACK;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      frame_start_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      h_st_q        <= h_st_d;
      v_st_q        <= v_st_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
    end
  end

  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;

endmodule
